// File: rtl/core_defines_pkg.sv
// Shared definitions for the EX-stage divide unit: data width, operation
// encodings, FSM state encoding and small decode helpers.
package core_defines_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract
// the divisor, keep the difference and set the quotient bit if it fits.
module div_step
  import core_defines_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // rem < divisor on entry, so the shifted value and the trial difference
  // both fit in XLEN+1 bits and trial[XLEN] is a true sign bit.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign trial   = shifted - {1'b0, divisor_i};

  assign rem_o = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/ex_div.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit feeding the register-file write port.
// Optional DIV_EARLY_OUT_EN skips the iteration when |dividend| < |divisor|.
module ex_div
  import core_defines_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ITER_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [XLEN-1:0] reg_wdata_o,
  output logic [4:0]      reg_waddr_o,
  output logic            reg_wen_o
);

  div_state_e        state_q, state_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic              sel_rem_q, sel_rem_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              wen_q, wen_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [4:0]        waddr_q, waddr_d;

  logic              op_signed;
  logic              dvd_neg, dvs_neg;
  logic [XLEN-1:0]   dvd_mag, dvs_mag;
  logic [XLEN-1:0]   step_rem, step_quo;
  logic [XLEN-1:0]   quo_fixed, rem_fixed;

  // Unsigned ops never flag a negative operand, so their magnitude is the raw value.
  assign op_signed = is_signed_op(op_i);
  assign dvd_neg   = op_signed & dividend_i[XLEN-1];
  assign dvs_neg   = op_signed & divisor_i[XLEN-1];
  assign dvd_mag   = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag   = dvs_neg ? -divisor_i  : divisor_i;

  div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign quo_fixed = neg_quo_q ? -quo_q : quo_q;
  assign rem_fixed = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_rem_d = sel_rem_q;
    rd_d      = rd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    busy_d    = (state_q != ST_IDLE);
    ready_d   = 1'b0;
    wen_d     = 1'b0;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sel_rem_d = is_rem_op(op_i);
          rd_d      = rd_addr_i;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          dvs_d     = dvs_mag;
          cnt_d     = '0;
          if (divisor_i == '0) begin
            // Division by zero: quotient all-ones, remainder is the raw dividend.
            res_d   = is_rem_op(op_i) ? dividend_i : '1;
            state_d = ST_DONE;
          end else begin
`ifdef DIV_EARLY_OUT_EN
            if (dvd_mag < dvs_mag) begin
              rem_d   = dvd_mag;
              quo_d   = '0;
              state_d = ST_FIX;
            end else begin
              rem_d   = '0;
              quo_d   = dvd_mag;
              state_d = ST_CALC;
            end
`else
            rem_d   = '0;
            quo_d   = dvd_mag;
            state_d = ST_CALC;
`endif
          end
        end
      end

      ST_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ITER_W'(XLEN - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        res_d   = sel_rem_q ? rem_fixed : quo_fixed;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        ready_d = 1'b1;
        wen_d   = (rd_q != ZERO_REG);
        wdata_d = res_q;
        waddr_d = rd_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything, including a launch and a completing result.
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ready_d = 1'b0;
      wen_d   = 1'b0;
      wdata_d = wdata_q;
      waddr_d = waddr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_rem_q <= 1'b0;
      rd_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      waddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_rem_q <= sel_rem_d;
      rd_q      <= rd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
    end
  end

  assign busy_o      = busy_q;
  assign ready_o     = ready_q;
  assign reg_wen_o   = wen_q;
  assign reg_wdata_o = wdata_q;
  assign reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, results, divide-by-zero,
// overflow, rd=0, flush, ignored start, async reset.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] reg_wdata_o;
  logic [4:0]  reg_waddr_o;
  logic        reg_wen_o;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  ex_div dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .rd_addr_i   (rd_addr_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wen_o   (reg_wen_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the unit idle; the next edge is cycle 0.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_d, input int exp_lat);
    int n;
    int busy_n;
    op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 0;
    busy_n = 0;
    while (ready_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (busy_o === 1'b1) busy_n++;
    end
    $display("op %s: cycle=%0d wdata=0x%08h waddr=%0d wen=%0b", tag, n, reg_wdata_o,
             reg_waddr_o, reg_wen_o);
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_lat));
    chk({tag, " wdata"}, reg_wdata_o, exp_d);
    chk({tag, " waddr"}, 32'(reg_waddr_o), 32'(rd));
    chk({tag, " wen"}, 32'(reg_wen_o), 32'(rd != 5'd0));
    @(posedge clk); #1;
    chk({tag, " pulse_end"}, {29'd0, ready_o, reg_wen_o, busy_o}, 32'd0);
    chk({tag, " wdata_hold"}, reg_wdata_o, exp_d);
  endtask

  initial begin
    int n;
    int wen_seen;
    int busy_seen;

    rst_n = 1'b0; start_i = 1'b0; op_i = 2'b00; dividend_i = '0; divisor_i = '0;
    rd_addr_i = '0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {reg_wdata_o[15:0], 8'd0, reg_waddr_o, ready_o, reg_wen_o, busy_o}, 32'd0);
    chk("reset wdata", reg_wdata_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("DIV 20/-3",   OP_DIV,  32'd20,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFFA, 34);
    do_op("REM 20%-3",   OP_REM,  32'd20,        32'hFFFF_FFFD, 5'd6,  32'h0000_0002, 34);
    do_op("REM -7%2",    OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 34);
    do_op("DIVU ff/2",   OP_DIVU, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'h7FFF_FFFF, 34);
    do_op("REMU ff%2",   OP_REMU, 32'hFFFF_FFFF, 32'd2,         5'd9,  32'h0000_0001, 34);
    do_op("DIV 7/0",     OP_DIV,  32'd7,         32'd0,         5'd10, 32'hFFFF_FFFF, 1);
    do_op("REM 7%0",     OP_REM,  32'd7,         32'd0,         5'd11, 32'h0000_0007, 1);
    do_op("DIVU 0/0",    OP_DIVU, 32'd0,         32'd0,         5'd12, 32'hFFFF_FFFF, 1);
    do_op("REM -5%0",    OP_REM,  32'hFFFF_FFFB, 32'd0,         5'd13, 32'hFFFF_FFFB, 1);
    do_op("DIV ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 34);
    do_op("REM ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 34);
    do_op("DIV 9/3 rd0", OP_DIV,  32'd9,         32'd3,         5'd0,  32'h0000_0003, 34);
    do_op("DIVU 3/9",    OP_DIVU, 32'd3,         32'd9,         5'd16, 32'h0000_0000, EARLY_LAT);
    do_op("REMU 3%9",    OP_REMU, 32'd3,         32'd9,         5'd17, 32'h0000_0003, EARLY_LAT);
    do_op("REM -3%9",    OP_REM,  32'hFFFF_FFFD, 32'd9,         5'd18, 32'hFFFF_FFFD, EARLY_LAT);

    // Flush in cycle 10, relaunch in cycle 12, ignored start in cycle 20.
    op_i = OP_DIV; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wen_seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (reg_wen_o === 1'b1 || ready_o === 1'b1) wen_seen++;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush no_pulse", {30'd0, ready_o, reg_wen_o}, 32'd0);
    op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd9; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 12;
    while (ready_o !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (n == 20) begin
        start_i = 1'b1; op_i = OP_DIV; dividend_i = 32'd1; divisor_i = 32'd1; rd_addr_i = 5'd4;
      end else begin
        start_i = 1'b0;
      end
      if (ready_o !== 1'b1 && reg_wen_o === 1'b1) wen_seen++;
    end
    $display("op DIVU 100/7 after flush: cycle=%0d wdata=0x%08h waddr=%0d wen=%0b", n,
             reg_wdata_o, reg_waddr_o, reg_wen_o);
    chk("flush stray_wen", 32'(wen_seen), 32'd0);
    chk("relaunch latency", 32'(n), 32'd46);
    chk("relaunch wdata", reg_wdata_o, 32'h0000_000E);
    chk("relaunch waddr", 32'(reg_waddr_o), 32'd9);
    chk("relaunch wen", 32'(reg_wen_o), 32'd1);
    @(posedge clk); #1;

    // Flush while in DONE suppresses the pulse and keeps the old result.
    op_i = OP_DIV; dividend_i = 32'd7; divisor_i = 32'd0; rd_addr_i = 5'd3; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    $display("op DIV 7/0 flushed in DONE: wdata=0x%08h waddr=%0d ready=%0b wen=%0b",
             reg_wdata_o, reg_waddr_o, ready_o, reg_wen_o);
    chk("done_flush pulse", {30'd0, ready_o, reg_wen_o}, 32'd0);
    chk("done_flush wdata", reg_wdata_o, 32'h0000_000E);
    chk("done_flush waddr", 32'(reg_waddr_o), 32'd9);
    @(posedge clk); #1;

    // start_i and flush_i together in IDLE: no launch.
    op_i = OP_DIVU; dividend_i = 32'd50; divisor_i = 32'd5; rd_addr_i = 5'd2;
    start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    busy_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (busy_o === 1'b1 || ready_o === 1'b1) busy_seen++;
    end
    $display("op start+flush in IDLE: busy/ready cycles=%0d", busy_seen);
    chk("start_flush no_launch", 32'(busy_seen), 32'd0);

    // Async reset in the middle of an operation.
    op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd9; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-op: busy=%0b wdata=0x%08h waddr=%0d", busy_o, reg_wdata_o,
             reg_waddr_o);
    chk("async_rst flags", {29'd0, ready_o, reg_wen_o, busy_o}, 32'd0);
    chk("async_rst wdata", reg_wdata_o, 32'd0);
    chk("async_rst waddr", 32'(reg_waddr_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("DIV 9/3 post-rst", OP_DIV, 32'd9, 32'd3, 5'd2, 32'h0000_0003, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
